// File: rtl/rename_map_table_multi_if.sv
// Dispatch-side bus of the rename map table: per-lane reads and renames, ROB-walk revert,
// and checkpoint save/restore/release with their status.
interface rename_map_table_multi_if #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned RENAME_WIDTH  = 2,
  parameter int unsigned CKPT_DEPTH    = 4,
  parameter int unsigned ROB_IDX_W     = 6
);
  localparam int unsigned AW = $clog2(NUM_ARCH_REGS);
  localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CW = $clog2(CKPT_DEPTH);
  localparam int unsigned RW = RENAME_WIDTH;

  logic [RW-1:0][AW-1:0]  src0_arch;
  logic [RW-1:0][PW-1:0]  src0_phys;
  logic [RW-1:0][AW-1:0]  src1_arch;
  logic [RW-1:0][PW-1:0]  src1_phys;
  logic [RW-1:0][AW-1:0]  old_dest_arch;
  logic [RW-1:0][PW-1:0]  old_dest_phys;
  logic [RW-1:0]          rename_valid;
  logic [RW-1:0][AW-1:0]  rename_arch;
  logic [RW-1:0][PW-1:0]  rename_phys;
  logic                   revert_valid;
  logic [AW-1:0]          revert_arch;
  logic [PW-1:0]          revert_safe_phys;
  logic [PW-1:0]          revert_spec_phys;
  logic                   save_valid;
  logic [ROB_IDX_W-1:0]   save_rob_index;
  logic [CW-1:0]          save_ckpt_id;
  logic                   restore_valid;
  logic [CW-1:0]          restore_ckpt_id;
  logic [ROB_IDX_W-1:0]   restore_rob_index;
  logic                   restore_success;
  logic                   release_valid;
  logic [CW-1:0]          release_ckpt_id;
  logic [ROB_IDX_W-1:0]   release_rob_index;
  logic                   release_success;
  logic [CW:0]            ckpt_count;
  logic                   ckpt_full;
  logic                   ckpt_empty;

  modport master (
    output src0_arch, src1_arch, old_dest_arch,
    output rename_valid, rename_arch, rename_phys,
    output revert_valid, revert_arch, revert_safe_phys, revert_spec_phys,
    output save_valid, save_rob_index,
    output restore_valid, restore_ckpt_id, restore_rob_index,
    output release_valid, release_ckpt_id, release_rob_index,
    input  src0_phys, src1_phys, old_dest_phys,
    input  save_ckpt_id, restore_success, release_success,
    input  ckpt_count, ckpt_full, ckpt_empty
  );

  modport slave (
    input  src0_arch, src1_arch, old_dest_arch,
    input  rename_valid, rename_arch, rename_phys,
    input  revert_valid, revert_arch, revert_safe_phys, revert_spec_phys,
    input  save_valid, save_rob_index,
    input  restore_valid, restore_ckpt_id, restore_rob_index,
    input  release_valid, release_ckpt_id, release_rob_index,
    output src0_phys, src1_phys, old_dest_phys,
    output save_ckpt_id, restore_success, release_success,
    output ckpt_count, ckpt_full, ckpt_empty
  );
endinterface

// File: rtl/rename_map_table_multi.sv
// Superscalar rename map table with in-group read bypass and a circular checkpoint FIFO.
// Optional feature macro: ZERO_REG_GUARD_EN (arch 0 pinned to phys 0, writes to it flagged).
module rename_map_table_multi #(
  parameter int unsigned NUM_ARCH_REGS = 32,
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned RENAME_WIDTH  = 2,
  parameter int unsigned CKPT_DEPTH    = 4,
  parameter int unsigned ROB_IDX_W     = 6
) (
  input  logic CLK,
  input  logic nRST,
  output logic DUT_error,
  rename_map_table_multi_if.slave bus
);
  localparam int unsigned PW = $clog2(NUM_PHYS_REGS);
  localparam int unsigned CW = $clog2(CKPT_DEPTH);
  localparam int unsigned RW = RENAME_WIDTH;

  typedef logic [NUM_ARCH_REGS-1:0][PW-1:0] map_t;

  map_t                 map_q, map_d;
  map_t                 ckpt_map_q [CKPT_DEPTH];
  map_t                 ckpt_map_d [CKPT_DEPTH];
  logic [ROB_IDX_W-1:0] ckpt_rob_q [CKPT_DEPTH];
  logic [ROB_IDX_W-1:0] ckpt_rob_d [CKPT_DEPTH];
  logic [CKPT_DEPTH-1:0] ckpt_valid_q, ckpt_valid_d;
  logic [CW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW:0]          count_q, count_d;
  logic                 err_q, err_d;

  logic [RW-1:0][PW-1:0] src0_rd, src1_rd, old_rd;
  logic                 full, restore_ok, release_ok, save_ok, revert_go, rename_go;
  logic [CW-1:0]        restore_off, slot_off;
  logic [CW:0]          live_from_restore;

  // Reads see the registered map plus renames from older lanes of the same group
  always_comb begin
    for (int j = 0; j < RW; j++) begin
      src0_rd[j] = map_q[bus.src0_arch[j]];
      src1_rd[j] = map_q[bus.src1_arch[j]];
      old_rd[j]  = map_q[bus.old_dest_arch[j]];
      for (int k = 0; k < j; k++) begin
        if (bus.rename_valid[k] && bus.rename_arch[k] == bus.src0_arch[j])     src0_rd[j] = bus.rename_phys[k];
        if (bus.rename_valid[k] && bus.rename_arch[k] == bus.src1_arch[j])     src1_rd[j] = bus.rename_phys[k];
        if (bus.rename_valid[k] && bus.rename_arch[k] == bus.old_dest_arch[j]) old_rd[j]  = bus.rename_phys[k];
      end
`ifdef ZERO_REG_GUARD_EN
      if (bus.src0_arch[j] == '0)     src0_rd[j] = '0;
      if (bus.src1_arch[j] == '0)     src1_rd[j] = '0;
      if (bus.old_dest_arch[j] == '0) old_rd[j]  = '0;
`endif
    end
  end

  assign full       = (count_q == (CW+1)'(CKPT_DEPTH));
  assign restore_ok = bus.restore_valid && ckpt_valid_q[bus.restore_ckpt_id] &&
                      (ckpt_rob_q[bus.restore_ckpt_id] == bus.restore_rob_index);
  // A restore of the head squashes it, so a same-cycle release of it is dropped
  assign release_ok = bus.release_valid && (bus.release_ckpt_id == head_q) && ckpt_valid_q[head_q] &&
                      (ckpt_rob_q[head_q] == bus.release_rob_index) &&
                      !(restore_ok && (bus.restore_ckpt_id == head_q));
  assign revert_go  = bus.revert_valid && !bus.restore_valid;
  assign rename_go  = !bus.restore_valid && !bus.revert_valid;
  assign save_ok    = bus.save_valid && rename_go && (!full || release_ok);

  // Next-state: restore > revert > {rename, save}; release applies alongside
  always_comb begin
    map_d        = map_q;
    ckpt_map_d   = ckpt_map_q;
    ckpt_rob_d   = ckpt_rob_q;
    ckpt_valid_d = ckpt_valid_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    err_d        = err_q;
    slot_off     = '0;
    restore_off       = bus.restore_ckpt_id - head_q;
    live_from_restore = count_q - {1'b0, restore_off};

    if ((bus.restore_valid || bus.revert_valid) && (bus.save_valid || (|bus.rename_valid))) err_d = 1'b1;
    if (bus.save_valid && rename_go && full && !release_ok) err_d = 1'b1;

    if (restore_ok) begin
      map_d = ckpt_map_q[bus.restore_ckpt_id];
      for (int s = 0; s < CKPT_DEPTH; s++) begin
        slot_off = CW'(s) - bus.restore_ckpt_id;
        if ({1'b0, slot_off} < live_from_restore) ckpt_valid_d[s] = 1'b0;
      end
      tail_d  = bus.restore_ckpt_id;
      count_d = {1'b0, restore_off};
    end else if (revert_go) begin
      if (map_q[bus.revert_arch] != bus.revert_spec_phys) err_d = 1'b1;
`ifdef ZERO_REG_GUARD_EN
      if (bus.revert_arch == '0) err_d = 1'b1;
      else                       map_d[bus.revert_arch] = bus.revert_safe_phys;
`else
      map_d[bus.revert_arch] = bus.revert_safe_phys;
`endif
    end else if (rename_go) begin
      for (int l = 0; l < RW; l++) begin
        if (bus.rename_valid[l]) begin
`ifdef ZERO_REG_GUARD_EN
          if (bus.rename_arch[l] == '0) err_d = 1'b1;
          else                          map_d[bus.rename_arch[l]] = bus.rename_phys[l];
`else
          map_d[bus.rename_arch[l]] = bus.rename_phys[l];
`endif
        end
      end
    end

    if (release_ok) begin
      ckpt_valid_d[head_q] = 1'b0;
      head_d  = head_q + 1'b1;
      count_d = count_d - 1'b1;
    end

    // Save after release so a full table can recycle the head slot in one cycle
    if (save_ok) begin
      ckpt_valid_d[tail_q] = 1'b1;
      ckpt_rob_d[tail_q]   = bus.save_rob_index;
      ckpt_map_d[tail_q]   = map_d;
      tail_d  = tail_q + 1'b1;
      count_d = count_d + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++) map_q[i] <= PW'(i);
      ckpt_valid_q <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      map_q        <= map_d;
      ckpt_valid_q <= ckpt_valid_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  // Checkpoint payload is qualified by ckpt_valid_q, so it needs no reset
  always_ff @(posedge CLK) begin
    ckpt_map_q <= ckpt_map_d;
    ckpt_rob_q <= ckpt_rob_d;
  end

  assign bus.src0_phys       = src0_rd;
  assign bus.src1_phys       = src1_rd;
  assign bus.old_dest_phys   = old_rd;
  assign bus.save_ckpt_id    = tail_q;
  assign bus.restore_success = restore_ok;
  assign bus.release_success = release_ok;
  assign bus.ckpt_count      = count_q;
  assign bus.ckpt_full       = full;
  assign bus.ckpt_empty      = (count_q == '0);
  assign DUT_error           = err_q;
endmodule
